eviction_fifo: RTL and testbench



---
 rtl/eviction_fifo.sv | 112 +++++++++++
 tb/tb_eviction_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/eviction_fifo.sv
// eviction_fifo: captures single-cycle cache eviction pulses into a circular
// FIFO and drains them first-word-fall-through over a valid/ready handshake.
// Provides almost_full back-pressure plus saturating accept/drop statistics.
module eviction_fifo #(
  parameter int ADDR_WIDTH        = 32,
  parameter int GRAD_WIDTH        = 16,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         evict_valid,
  input  logic [ADDR_WIDTH-1:0]        evict_address,
  input  logic signed [GRAD_WIDTH-1:0] evict_value,
  output logic                         out_valid,
  output logic [ADDR_WIDTH-1:0]        out_address,
  output logic signed [GRAD_WIDTH-1:0] out_value,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic                         almost_full,
  output logic                         drop_sticky,
  output logic [CNT_WIDTH-1:0]         drop_count,
  output logic [CNT_WIDTH-1:0]         accept_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // Storage is never reset; only pointers and occupancy define validity.
  logic [ADDR_WIDTH-1:0]        r_addr_mem [DEPTH];
  logic signed [GRAD_WIDTH-1:0] r_val_mem  [DEPTH];

  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [OCC_W-1:0]     r_count;
  logic                 r_drop_sticky;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic [CNT_WIDTH-1:0] r_accept_cnt;

  logic w_out_valid;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & out_ready;
  // A full FIFO can still take a new entry when the head leaves this cycle.
  assign w_push      = evict_valid & ((r_count < OCC_W'(DEPTH)) | w_pop);
  assign w_drop      = evict_valid & ~w_push;

  // Pointer, occupancy and statistics state; reset discards any same-cycle push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_drop_sticky <= 1'b0;
      r_drop_cnt    <= '0;
      r_accept_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
        r_accept_cnt <= sat_inc(r_accept_cnt);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_drop) begin
        r_drop_sticky <= 1'b1;
        r_drop_cnt    <= sat_inc(r_drop_cnt);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage write at the write pointer; suppressed while in reset.
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_addr_mem[r_wr_ptr] <= evict_address;
      r_val_mem[r_wr_ptr]  <= evict_value;
    end
  end

  // Head presentation: zeroed when empty so idle outputs are clean.
  always_comb begin
    out_address = '0;
    out_value   = '0;
    if (w_out_valid) begin
      out_address = r_addr_mem[r_rd_ptr];
      out_value   = r_val_mem[r_rd_ptr];
    end
  end

  assign out_valid    = w_out_valid;
  assign fifo_count   = r_count;
  // Depends only on registered occupancy so upstream stall sees a clean path.
  assign almost_full  = (r_count >= OCC_W'(ALMOST_FULL_LEVEL));
  assign drop_sticky  = r_drop_sticky;
  assign drop_count   = r_drop_cnt;
  assign accept_count = r_accept_cnt;

endmodule

// File: tb/tb_eviction_fifo.sv
// Directed self-checking bench for eviction_fifo.
module tb_eviction_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        evict_valid;
  logic [31:0] evict_address;
  logic [15:0] evict_value;
  logic        out_valid;
  logic [31:0] out_address;
  logic [15:0] out_value;
  logic        out_ready;
  logic [4:0]  fifo_count;
  logic        almost_full;
  logic        drop_sticky;
  logic [31:0] drop_count;
  logic [31:0] accept_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_val [16];
  logic [15:0] strm_val;
  logic [31:0] strm_addr;

  eviction_fifo #(
    .ADDR_WIDTH(32), .GRAD_WIDTH(16), .DEPTH(16),
    .ALMOST_FULL_LEVEL(12), .CNT_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset),
    .evict_valid(evict_valid), .evict_address(evict_address), .evict_value(evict_value),
    .out_valid(out_valid), .out_address(out_address), .out_value(out_value),
    .out_ready(out_ready), .fifo_count(fifo_count), .almost_full(almost_full),
    .drop_sticky(drop_sticky), .drop_count(drop_count), .accept_count(accept_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stream_value(input int j);
    logic [31:0] t;
    t = (j * 1733) ^ 32'h0000_8000;
    return t[15:0];
  endfunction

  initial begin
    reset = 1'b1; evict_valid = 1'b0; evict_address = '0; evict_value = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset then idle
    chk("idle_count", fifo_count, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_addr", out_address, 0);
    chk("idle_value", out_value, 0);
    chk("idle_af", almost_full, 0);
    chk("idle_drops", drop_count, 0);
    chk("idle_sticky", drop_sticky, 0);
    chk("idle_accepts", accept_count, 0);

    // Single eviction, held while out_ready=0
    evict_valid = 1'b1; evict_address = 32'h0000_1403; evict_value = 16'hFED4;
    tick();
    evict_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("single_valid", out_valid, 1);
      chk("single_addr", out_address, 32'h0000_1403);
      chk("single_value", out_value, 16'hFED4);
      chk("single_count", fifo_count, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_valid", out_valid, 0);
    chk("single_pop_count", fifo_count, 0);
    chk("single_pop_value", out_value, 0);
    chk("single_accepts", accept_count, 1);

    // Fresh reset before fill
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_accepts", accept_count, 0);

    // Fill 16 entries with out_ready=0
    for (int i = 1; i <= 16; i++) begin
      evict_valid = 1'b1; evict_address = 32'h100 + 32'(i); evict_value = 16'(i);
      tick();
      chk("fill_count", fifo_count, 64'(i));
      chk("fill_af", almost_full, (i >= 12) ? 64'd1 : 64'd0);
    end
    evict_value = 16'd17; evict_address = 32'h111;
    tick();
    evict_valid = 1'b0;
    chk("overflow_drops", drop_count, 1);
    chk("overflow_sticky", drop_sticky, 1);
    chk("overflow_accepts", accept_count, 16);
    chk("overflow_count", fifo_count, 16);
    chk("full_head", out_value, 1);

    // Full with simultaneous push and pop
    evict_valid = 1'b1; evict_address = 32'h0000_ABCD; evict_value = 16'h7FFF; out_ready = 1'b1;
    tick();
    evict_valid = 1'b0;
    chk("simul_drops", drop_count, 1);
    chk("simul_count", fifo_count, 16);
    chk("simul_accepts", accept_count, 17);
    for (int k = 0; k < 15; k++) exp_val[k] = 16'(k + 2);
    exp_val[15] = 16'h7FFF;
    for (int k = 0; k < 16; k++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_value", out_value, exp_val[k]);
      chk("drain_addr", out_address, (k < 15) ? 64'(32'h102 + 32'(k)) : 64'h0000_ABCD);
      tick();
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_count", fifo_count, 0);
    chk("drain_af", almost_full, 0);

    // Streaming with continuous ready; pointers wrap at 16 and 32
    for (int j = 0; j < 40; j++) begin
      strm_val = stream_value(j);
      strm_addr = 32'h2000_0000 + 32'(j);
      evict_valid = 1'b1; evict_address = strm_addr; evict_value = strm_val;
      tick();
      chk("stream_count", fifo_count, 1);
      chk("stream_value", out_value, strm_val);
      chk("stream_addr", out_address, strm_addr);
    end
    evict_valid = 1'b0;
    tick();
    chk("stream_end_count", fifo_count, 0);
    chk("stream_drops", drop_count, 1);
    chk("stream_accepts", accept_count, 57);
    tick();
    chk("ready_idle_count", fifo_count, 0);
    chk("ready_idle_valid", out_valid, 0);
    out_ready = 1'b0;

    // Reset mid-operation with a concurrent strobe
    for (int i = 0; i < 7; i++) begin
      evict_valid = 1'b1; evict_address = 32'h300 + 32'(i); evict_value = 16'h10 + 16'(i);
      tick();
    end
    chk("mid_count", fifo_count, 7);
    reset = 1'b1; evict_valid = 1'b1; evict_address = 32'hDEAD; evict_value = 16'h5555;
    tick();
    reset = 1'b0; evict_valid = 1'b0;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_accepts", accept_count, 0);
    chk("mid_rst_drops", drop_count, 0);
    chk("mid_rst_sticky", drop_sticky, 0);
    chk("mid_rst_value", out_value, 0);
    evict_valid = 1'b1; evict_address = 32'h42; evict_value = 16'h0042;
    tick();
    evict_valid = 1'b0;
    chk("post_rst_value", out_value, 16'h0042);
    chk("post_rst_addr", out_address, 32'h42);
    chk("post_rst_count", fifo_count, 1);
    chk("post_rst_accepts", accept_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
